control_seq: RTL
================

# control_seq

Multi-cycle control sequencer for the WF8 core. It replaces purely combinational opcode decode with a FETCH/DECODE/EXEC/MEM/WB state machine. It latches the opcode, drives the existing datapath control lines only in the states where they are valid, and handshakes with memory under a timeout. It sits between the instruction fetch path and the datapath (ALU, register file, cpu_bus, memory port).

## Interface
- OPCODE_W, 5: opcode width, ≥5; bits above [4] are reserved and must be zero.
- ALU_MODE_W, `ALU_MODE_COUNT: width of alu_mode.
- MEM_TIMEOUT, 15: maximum MEM-state cycles waiting for mem_ack, ≥1.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  opcode valid; sampled only in FETCH.
- opcode  in  OPCODE_W  instruction opcode; latched when instr_valid is high in FETCH.
- mem_ack  in  1  memory transfer complete; sampled only in MEM.
- fetch_req  out  1  high throughout FETCH.
- alu_mode  out  ALU_MODE_W  ALU operation.
- reg_b_read_en  out  1  reg_b drives cpu_bus.
- reg_b_write_en  out  1  reg_b captures result.
- alu_a_sel  out  1  0 = accumulator, 1 = PC.
- alu_b_sel  out  1  0 = register x0–x6, 1 = immediate.
- mem_out_en  out  1  load request.
- mem_write_en  out  1  store request.
- pc_en  out  1  PC update strobe.
- instr_done  out  1  one-cycle retire pulse.
- fault  out  1  sticky fault flag.
- retired  out  CNT_W  retired-instruction count.

## Operation
- Decode uses latched opcode grp = op_q[4:1]:
  - 000x ADD: add, addi.
  - 001x SHIFT: sh, shi.
  - 0100 NOT; 0101 AND; 0110 OR; 0111 XOR.
  - 1000 BYPASS_A: cpy, cpypc.
  - 1001 BYPASS_A: lb.
  - 1010 BYPASS_A: sb.
  - 1011 BYPASS_B: jmpadr.
  - 11xx ADD: jmpi, blt, bge, beq, bneq.
- reg_b_read_en: all opcodes except addi, shi, jmpi (grp 1100).
- alu_a_sel: grp 11xx, or op_q == 10001 (cpypc).
- alu_b_sel: grp 11xx, addi, shi.
- writes_b: grp 0xxx and grp 100x.
- States and transitions:
  - FETCH: fetch_req = 1. On instr_valid, latch op_q and go to DECODE.
  - DECODE: go to FAULT if OPCODE_W > 5 and op_q[OPCODE_W-1:5] ≠ 0; otherwise go to EXEC.
  - EXEC: go to MEM if grp is 1001 or 1010; otherwise go to WB.
  - MEM: on mem_ack, go to WB. If MEM_TIMEOUT cycles pass with no ack, go to FAULT.
  - WB: go to FETCH.
  - FAULT: terminal; left only by rst.
- Outputs by state:
  - FETCH, DECODE, FAULT: all control outputs 0.
  - EXEC and MEM: alu_mode, alu_a_sel, alu_b_sel, reg_b_read_en decoded from op_q.
  - MEM only: mem_out_en (lb) or mem_write_en (sb), held until ack or timeout.
  - WB: the EXEC signals are held, plus reg_b_write_en = writes_b, pc_en = 1, instr_done = 1.
- retired increments on every WB cycle and wraps modulo 2^CNT_W.
- fault is set on entry to FAULT and cleared only by rst.

## Timing
- Reset (async assert, release sampled on clk): state = FETCH, op_q = 0, wait counter = 0, retired = 0, fault = 0. fetch_req = 1 from reset; all other outputs 0.
- Non-memory instruction: FETCH, DECODE, EXEC, WB. Minimum 4 cycles per instruction when instr_valid is high on the first FETCH cycle.
- Memory instruction: 4 + k cycles, where k is the number of MEM cycles up to and including the ack cycle, 1 ≤ k ≤ MEM_TIMEOUT.
- An ack in the same cycle as timeout expiry counts as success (go to WB, not FAULT).
- The wait counter clears on MEM entry.
- mem_ack outside MEM and instr_valid outside FETCH are ignored and have no effect.
- Back-to-back: WB is always followed by one FETCH cycle, so instr_valid can be accepted the cycle after instr_done.
- rst asserted mid-MEM deasserts mem_out_en and mem_write_en immediately (asynchronously). No WB occurs and retired is not incremented.
- Control outputs are decoded from registered state and op_q only; there is no combinational path from opcode, mem_ack or instr_valid to any output.

## Test plan
- Add trace: opcode 00000 with instr_valid high at reset release.
  - Expect fetch_req, then DECODE, then EXEC with alu_mode = ADD, reg_b_read_en = 1, alu_b_sel = 0.
  - WB with reg_b_write_en = 1, pc_en = 1, instr_done = 1. retired = 1 after 4 cycles.
- lb (10010), mem_ack on the 3rd MEM cycle: mem_out_en high for exactly 3 cycles, mem_write_en = 0, WB writes reg_b, total 7 cycles.
- sb (10100), no ack, MEM_TIMEOUT = 15: mem_write_en high 15 cycles, then fault = 1.
  - All outputs 0, and further instr_valid is ignored until rst.
  - Also: ack on the 15th cycle, which must reach WB.
- jmpi (11000) and cpypc (10001):
  - jmpi: alu_a_sel = 1, alu_b_sel = 1, reg_b_read_en = 0, reg_b_write_en = 0 in WB.
  - cpypc: alu_a_sel = 1, alu_mode = BYPASS_A, reg_b_write_en = 1.
- OPCODE_W = 7:
  - opcode 0100000 gives FAULT directly after DECODE.
  - Separately, rst pulsed mid-MEM returns to FETCH with retired unchanged (0).
- CNT_W = 4: 17 back-to-back add instructions give retired = 1 (wrap at 16). Stray mem_ack pulses during FETCH and EXEC have no effect.

Source files
------------

// File: rtl/control_seq.sv
// control_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the WF8 core.
// Every datapath control line is decoded from the registered state and latched opcode only.
`ifndef ALU_MODE_COUNT
`define ALU_MODE_COUNT 3
`endif

module control_seq #(
    parameter int OPCODE_W    = 5,
    parameter int ALU_MODE_W  = `ALU_MODE_COUNT,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  mem_ack,
    output logic                  fetch_req,
    output logic [ALU_MODE_W-1:0] alu_mode,
    output logic                  reg_b_read_en,
    output logic                  reg_b_write_en,
    output logic                  alu_a_sel,
    output logic                  alu_b_sel,
    output logic                  mem_out_en,
    output logic                  mem_write_en,
    output logic                  pc_en,
    output logic                  instr_done,
    output logic                  fault,
    output logic [CNT_W-1:0]      retired
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SHIFT, ALU_NOT, ALU_AND, ALU_OR, ALU_XOR, ALU_BYPASS_A, ALU_BYPASS_B
    } alu_op_t;

    state_t              state;
    state_t              next_state;
    logic [OPCODE_W-1:0] op_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                fault_q;
    logic [CNT_W-1:0]    retired_q;

    logic [3:0] grp;
    logic       rsv_bad;
    alu_op_t    dec_mode;
    logic       is_addi, is_shi, is_load, is_store;
    logic       dec_rb_rd, dec_a_sel, dec_b_sel, writes_b;
    logic       exec_on;

    assign grp = op_q[4:1];

    generate
        if (OPCODE_W > 5) begin : g_rsv
            assign rsv_bad = |op_q[OPCODE_W-1:5];
        end else begin : g_no_rsv
            assign rsv_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        dec_mode = ALU_ADD;
        case (grp)
            4'b0000, 4'b0001:          dec_mode = ALU_ADD;
            4'b0010, 4'b0011:          dec_mode = ALU_SHIFT;
            4'b0100:                   dec_mode = ALU_NOT;
            4'b0101:                   dec_mode = ALU_AND;
            4'b0110:                   dec_mode = ALU_OR;
            4'b0111:                   dec_mode = ALU_XOR;
            4'b1000, 4'b1001, 4'b1010: dec_mode = ALU_BYPASS_A;
            4'b1011:                   dec_mode = ALU_BYPASS_B;
            default:                   dec_mode = ALU_ADD;
        endcase
    end

    assign is_addi   = (op_q[4:0] == 5'b00001);
    assign is_shi    = (op_q[4:0] == 5'b00011);
    assign is_load   = (grp == 4'b1001);
    assign is_store  = (grp == 4'b1010);
    assign dec_rb_rd = !(is_addi || is_shi || grp == 4'b1100);
    assign dec_a_sel = (grp[3:2] == 2'b11) || (op_q[4:0] == 5'b10001);
    assign dec_b_sel = (grp[3:2] == 2'b11) || is_addi || is_shi;
    assign writes_b  = !grp[3] || (grp[3:1] == 3'b100);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // An ack landing on the final allowed MEM cycle wins over the timeout.
    always_comb begin
        next_state     = state;
        exec_on        = 1'b0;
        fetch_req      = 1'b0;
        mem_out_en     = 1'b0;
        mem_write_en   = 1'b0;
        reg_b_write_en = 1'b0;
        pc_en          = 1'b0;
        instr_done     = 1'b0;
        case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) next_state = S_DECODE;
            end
            S_DECODE: next_state = rsv_bad ? S_FAULT : S_EXEC;
            S_EXEC: begin
                exec_on    = 1'b1;
                next_state = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                exec_on      = 1'b1;
                mem_out_en   = is_load;
                mem_write_en = is_store;
                if (mem_ack) begin
                    next_state = S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_FAULT;
                end
            end
            S_WB: begin
                exec_on        = 1'b1;
                reg_b_write_en = writes_b;
                pc_en          = 1'b1;
                instr_done     = 1'b1;
                next_state     = S_FETCH;
            end
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FETCH;
        endcase
        alu_mode      = exec_on ? ALU_MODE_W'(dec_mode) : '0;
        alu_a_sel     = exec_on & dec_a_sel;
        alu_b_sel     = exec_on & dec_b_sel;
        reg_b_read_en = exec_on & dec_rb_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            wait_cnt  <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state == S_FETCH && instr_valid) op_q <= opcode;
            if (state == S_EXEC) begin
                wait_cnt <= '0;
            end else if (state == S_MEM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (next_state == S_FAULT) fault_q <= 1'b1;
            if (state == S_WB) retired_q <= retired_q + 1'b1;
        end
    end

    assign fault   = fault_q;
    assign retired = retired_q;

endmodule
